// File: rtl/cnt_seq_pkg.sv
// Purpose : shared state encoding for the counter run controller.
// Latency : n/a (types and constants only).
// Contents: STATE_W and the state_t enum (IDLE=00 RUN=01 HOLD=10 DONE=11).
package cnt_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/cnt_seq_ctrl_cnt_core.sv
// Purpose : WIDTH-bit count register with synchronous clear and increment enable.
// Latency : q updates on the rising edge after clr/en are presented.
// Ports   : clk, rst (sync, active-high), clr (wins over en), en (q <= q+1), q.
module cnt_core #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Purpose : run controller (start/pause/stop, one-shot or auto-reload) for a WIDTH-bit up-counter.
// Latency : start edge -> count=0 in RUN; +1 per step; done is a one-cycle registered pulse.
// Ports   : clk, rst, start, stop, pause, auto_reload, tc_in -> count, state, busy, done.
// Config  : define CNT_SEQ_PRESCALE_EN to take a step only every PRESCALE-th RUN edge.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               auto_reload,
  input  logic [WIDTH-1:0]   tc_in,
  output logic [WIDTH-1:0]   count,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               done
);

  // A PRESCALE below 1 is an illegal configuration; the counter then never steps.
  localparam bit PRESCALE_OK = (PRESCALE >= 1);

  state_t           state_q;
  logic [WIDTH-1:0] tc_reg;
  logic             done_q;

  logic match;
  logic start_acc;
  logic run_go;
  logic psc_hit;
  logic step;
  logic cnt_clr;
  logic cnt_en;

  always_comb begin
    match     = (count == tc_reg);
    // pause only matters in RUN/HOLD, so it does not block a start from IDLE/DONE.
    start_acc = start && !stop && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    run_go    = (state_q == ST_RUN) && !stop && !pause;
    step      = run_go && psc_hit && PRESCALE_OK;
    // IDLE keeps the counter pinned at 0; a wrap in auto-reload also clears it.
    cnt_clr   = stop || (state_q == ST_IDLE) || start_acc || (step && match && auto_reload);
    // At the terminal count in one-shot mode the counter holds at tc_reg.
    cnt_en    = step && !match;
  end

`ifdef CNT_SEQ_PRESCALE_EN
  localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc;

  assign psc_hit = (psc == PSC_LAST);

  // Advances only on un-paused RUN edges; any other cycle (stop, start,
  // HOLD entry, HOLD, IDLE, DONE) leaves it at 0 so each run phase starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc <= '0;
    end else if (run_go) begin
      psc <= psc_hit ? '0 : psc + PSC_W'(1);
    end else begin
      psc <= '0;
    end
  end
`else
  assign psc_hit = 1'b1;
`endif

  cnt_core #(
    .WIDTH (WIDTH)
  ) u_cnt_core (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tc_reg  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              tc_reg  <= tc_in;
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (pause) begin
              state_q <= ST_HOLD;
            end else if (step && match) begin
              done_q <= 1'b1;
              if (!auto_reload) begin
                state_q <= ST_DONE;
              end
            end
          end
          ST_HOLD: begin
            if (!pause) begin
              state_q <= ST_RUN;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign state = state_q;
  assign done  = done_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
module tb_cnt_seq_ctrl;

  localparam logic [1:0] SI = 2'b00;
  localparam logic [1:0] SR = 2'b01;
  localparam logic [1:0] SH = 2'b10;
  localparam logic [1:0] SD = 2'b11;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic       auto_reload;
  logic [2:0] tc_in;
  logic [2:0] count;
  logic [1:0] state;
  logic       busy;
  logic       done;

  cnt_seq_ctrl #(
    .WIDTH    (3),
    .PRESCALE (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .auto_reload (auto_reload),
    .tc_in       (tc_in),
    .count       (count),
    .state       (state),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [2:0] c;
    logic [1:0] s;
    logic       b;
    logic       d;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_push = 0;

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected after the following rising edge.
  task automatic v(input logic r, input logic st, input logic p, input logic sa,
                   input logic ar, input logic [2:0] tc,
                   input logic [2:0] ec, input logic [1:0] es, input logic ed);
    exp_t e;
    @(negedge clk);
    rst         = r;
    stop        = st;
    pause       = p;
    start       = sa;
    auto_reload = ar;
    tc_in       = tc;
    e.idx = n_push;
    e.c   = ec;
    e.s   = es;
    e.b   = (es == SR) || (es == SH);
    e.d   = ed;
    exp_q.push_back(e);
    n_push++;
  endtask

  // Monitor: one observation per rising edge, compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (count !== e.c || state !== e.s || busy !== e.b || done !== e.d) begin
          n_miss++;
          $display("FAIL vec%0d: got count=%0d state=%b busy=%b done=%b, want count=%0d state=%b busy=%b done=%b",
                   e.idx, count, state, busy, done, e.c, e.s, e.b, e.d);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stop = 1'b0; pause = 1'b0; start = 1'b0; auto_reload = 1'b0; tc_in = 3'd0;

    // reset state
    v(1,0,0,0,0,0, 0,SI,0);
    v(1,0,0,0,0,0, 0,SI,0);
    v(0,0,0,0,0,0, 0,SI,0);

`ifndef CNT_SEQ_PRESCALE_EN
    // one-shot to TC=5, then restart from DONE
    v(0,0,0,1,0,5, 0,SR,0);
    v(0,0,0,0,0,5, 1,SR,0);
    v(0,0,0,0,0,5, 2,SR,0);
    v(0,0,0,0,0,5, 3,SR,0);
    v(0,0,0,0,0,5, 4,SR,0);
    v(0,0,0,0,0,5, 5,SR,0);
    v(0,0,0,0,0,1, 5,SD,1);
    v(0,0,0,0,0,1, 5,SD,0);
    v(0,0,0,1,0,5, 0,SR,0);
    v(0,0,0,0,0,5, 1,SR,0);
    v(0,1,0,0,0,5, 0,SI,0);

    // auto-reload at TC=7: done on each wrap, busy throughout
    v(0,0,0,1,1,7, 0,SR,0);
    for (int w = 0; w < 2; w++) begin
      for (int k = 1; k < 8; k++) v(0,0,0,0,1,7, 3'(k),SR,0);
      v(0,0,0,0,1,7, 0,SR,1);
    end
    v(0,0,0,0,1,7, 1,SR,0);
    v(0,1,0,0,1,7, 0,SI,0);

    // pause at count=3 for 4 cycles; start/tc_in ignored while running
    v(0,0,0,1,0,6, 0,SR,0);
    v(0,0,0,1,0,0, 1,SR,0);
    v(0,0,0,1,0,0, 2,SR,0);
    v(0,0,0,0,0,0, 3,SR,0);
    for (int k = 0; k < 4; k++) v(0,0,1,0,0,0, 3,SH,0);
    v(0,0,0,0,0,0, 3,SR,0);
    v(0,0,0,0,0,0, 4,SR,0);
    v(0,0,0,0,0,0, 5,SR,0);
    v(0,0,0,0,0,0, 6,SR,0);
    v(0,0,0,0,0,0, 6,SD,1);
    v(0,0,0,0,0,0, 6,SD,0);

    // reset held 2 cycles mid-run at count=4
    v(0,0,0,1,0,7, 0,SR,0);
    v(0,0,0,0,0,7, 1,SR,0);
    v(0,0,0,0,0,7, 2,SR,0);
    v(0,0,0,0,0,7, 3,SR,0);
    v(0,0,0,0,0,7, 4,SR,0);
    v(1,0,0,0,0,7, 0,SI,0);
    v(1,0,0,0,0,7, 0,SI,0);
    v(0,0,0,0,0,7, 0,SI,0);

    // stop with pause; stop on the terminal match; stop from HOLD
    v(0,0,0,1,0,5, 0,SR,0);
    v(0,0,0,0,0,5, 1,SR,0);
    v(0,0,0,0,0,5, 2,SR,0);
    v(0,1,1,0,0,5, 0,SI,0);
    v(0,0,0,1,0,2, 0,SR,0);
    v(0,0,0,0,0,2, 1,SR,0);
    v(0,0,0,0,0,2, 2,SR,0);
    v(0,1,0,0,0,2, 0,SI,0);
    v(0,0,0,0,0,2, 0,SI,0);
    v(0,0,0,1,0,5, 0,SR,0);
    v(0,0,1,0,0,5, 0,SH,0);
    v(0,1,1,0,0,5, 0,SI,0);

    // TC=0 one-shot; tc_in change during RUN ignored; TC=0 auto-reload
    v(0,0,0,1,0,0, 0,SR,0);
    v(0,0,0,0,0,0, 0,SD,1);
    v(0,0,0,0,0,0, 0,SD,0);
    v(0,0,0,1,0,4, 0,SR,0);
    v(0,0,0,0,0,3, 1,SR,0);
    v(0,0,0,0,0,3, 2,SR,0);
    v(0,0,0,0,0,3, 3,SR,0);
    v(0,0,0,0,0,3, 4,SR,0);
    v(0,0,0,0,0,3, 4,SD,1);
    v(0,0,0,1,1,0, 0,SR,0);
    v(0,0,0,0,1,0, 0,SR,1);
    v(0,0,0,0,1,0, 0,SR,1);
    v(0,1,0,0,1,0, 0,SI,0);
`else
    // PRESCALE=4, TC=2: one step every 4th RUN edge
    v(0,0,0,1,0,2, 0,SR,0);
    v(0,0,0,0,0,2, 0,SR,0);
    v(0,0,0,0,0,2, 0,SR,0);
    v(0,0,0,0,0,2, 0,SR,0);
    v(0,0,0,0,0,2, 1,SR,0);
    v(0,0,0,0,0,2, 1,SR,0);
    v(0,0,0,0,0,2, 1,SR,0);
    v(0,0,0,0,0,2, 1,SR,0);
    v(0,0,0,0,0,2, 2,SR,0);
    v(0,0,0,0,0,2, 2,SR,0);
    v(0,0,0,0,0,2, 2,SR,0);
    v(0,0,0,0,0,2, 2,SR,0);
    v(0,0,0,0,0,2, 2,SD,1);
    v(0,0,0,0,0,2, 2,SD,0);
    v(0,1,0,0,0,2, 0,SI,0);
`endif

    v(0,0,0,0,0,0, 0,SI,0);

    // bounded drain of the scoreboard
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
    #2;
    if (exp_q.size() > 0 || n_vec != n_push) begin
      n_miss++;
      $display("FAIL drain: got %0d checked with %0d pending, want %0d checked with 0 pending",
               n_vec, exp_q.size(), n_push);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
